// File: rtl/reg_enable_sequencer.sv
// Purpose: walks a run of register indices and drives one-hot Rout/Rin enables, one register at a time.
// Latency: enables start the cycle after acceptance, each held HOLD cycles; done follows the last one.
// Backpressure: req_ready is high only in IDLE; abort cancels an active walk without a done pulse.
module reg_enable_sequencer #(
  parameter int N_REGS = 32,
  parameter int SEL_W  = 5,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [SEL_W-1:0]  req_cnt,
  input  logic              req_dir,
  input  logic              abort,
  output logic [N_REGS-1:0] en_out,
  output logic [N_REGS-1:0] en_in,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              busy,
  output logic              done
);

  // Hold counter only ever needs to reach HOLD-1 <= 15.
  localparam int HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_REGS - 1);

  if (HOLD < 1 || HOLD > 16) begin : g_bad_hold
    $error("reg_enable_sequencer: HOLD must be within 1..16");
  end

  if ((1 << SEL_W) < N_REGS) begin : g_bad_sel_w
    $error("reg_enable_sequencer: SEL_W too narrow for N_REGS");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    remaining;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                dir;
  logic [SEL_W-1:0]    next_sel;

  function automatic logic [N_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next index in the walk; the top register wraps back to index 0.
  always_comb begin
    next_sel = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
  end

  // Sequencer FSM; every output is a register so enables are glitch-free at the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur_sel   <= '0;
      remaining <= '0;
      hold_cnt  <= '0;
      dir       <= 1'b0;
      en_out    <= '0;
      en_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (req_valid) begin
            cur_sel   <= req_sel;
            remaining <= req_cnt;
            dir       <= req_dir;
            hold_cnt  <= '0;
            en_out    <= req_dir ? '0 : onehot(req_sel);
            en_in     <= req_dir ? onehot(req_sel) : '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          if (abort) begin
            // Cancel wins over hold expiry and advancing; no done pulse.
            en_out    <= '0;
            en_in     <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            hold_cnt  <= '0;
            state     <= S_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            if (remaining == '0) begin
              en_out   <= '0;
              en_in    <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              hold_cnt <= '0;
              state    <= S_DONE;
            end else begin
              // Move straight to the next register, no idle gap.
              cur_sel   <= next_sel;
              remaining <= remaining - 1'b1;
              hold_cnt  <= '0;
              en_out    <= dir ? '0 : onehot(next_sel);
              en_in     <= dir ? onehot(next_sel) : '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          en_out    <= '0;
          en_in     <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_enable_sequencer.sv
// Purpose: checks two sequencers (HOLD=1 and HOLD=2) sharing one stimulus stream against a timeline model.
// Latency: outputs compared every cycle on the falling edge, model advanced on the rising edge.
// Backpressure: request acceptance is predicted from the model's own idle/busy view of each instance.
module tb_reg_enable_sequencer;

  localparam int H0 = 1;
  localparam int H1 = 2;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [4:0]  req_sel;
  logic [4:0]  req_cnt;
  logic        req_dir;
  logic        abort;

  logic        rdy_s [2];
  logic [31:0] eo_s  [2];
  logic [31:0] ei_s  [2];
  logic [4:0]  cs_s  [2];
  logic        bsy_s [2];
  logic        dn_s  [2];

  int n_checks;
  int n_errors;

  // Reference model: each instance is either idle or at offset t cycles into a walk.
  logic       active   [2];
  int         m_t      [2];
  int         m_sel    [2];
  int         m_cnt    [2];
  logic       m_dir    [2];
  logic [4:0] last_sel [2];

  // Per-run accumulators for whole-sequence checks.
  logic [31:0] acc_out   [2];
  logic [31:0] acc_in    [2];
  int          done_cnt  [2];
  int          drive_cyc [2];

  reg_enable_sequencer #(.N_REGS(32), .SEL_W(5), .HOLD(H0)) u_dut_h1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_s[0]),
    .req_sel(req_sel), .req_cnt(req_cnt), .req_dir(req_dir), .abort(abort),
    .en_out(eo_s[0]), .en_in(ei_s[0]), .cur_sel(cs_s[0]), .busy(bsy_s[0]), .done(dn_s[0])
  );

  reg_enable_sequencer #(.N_REGS(32), .SEL_W(5), .HOLD(H1)) u_dut_h2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_s[1]),
    .req_sel(req_sel), .req_cnt(req_cnt), .req_dir(req_dir), .abort(abort),
    .en_out(eo_s[1]), .en_in(ei_s[1]), .cur_sel(cs_s[1]), .busy(bsy_s[1]), .done(dn_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      active[i]   = 1'b0;
      m_t[i]      = 0;
      last_sel[i] = 5'd0;
    end
  endtask

  task automatic clear_acc();
    for (int i = 0; i < 2; i++) begin
      acc_out[i]   = '0;
      acc_in[i]    = '0;
      done_cnt[i]  = 0;
      drive_cyc[i] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs presented before it.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int h;
      int total;
      h     = hold_of(i);
      total = h * (m_cnt[i] + 1);
      if (active[i]) begin
        if (abort && m_t[i] <= total) begin
          active[i]   = 1'b0;
          last_sel[i] = 5'((m_sel[i] + (m_t[i] - 1) / h) % 32);
        end else if (m_t[i] > total) begin
          active[i]   = 1'b0;
          last_sel[i] = 5'((m_sel[i] + m_cnt[i]) % 32);
        end else begin
          m_t[i]++;
        end
      end else if (req_valid) begin
        active[i] = 1'b1;
        m_t[i]    = 1;
        m_sel[i]  = int'(req_sel);
        m_cnt[i]  = int'(req_cnt);
        m_dir[i]  = req_dir;
      end
    end
  endtask

  // Compare every output of both instances with the model's view of the current cycle.
  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e_out;
      logic [31:0] e_in;
      logic [4:0]  e_sel;
      logic        e_busy;
      logic        e_done;
      logic        e_rdy;
      int          h;
      int          total;
      h      = hold_of(i);
      total  = h * (m_cnt[i] + 1);
      e_out  = '0;
      e_in   = '0;
      e_sel  = last_sel[i];
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rdy  = 1'b1;
      if (active[i]) begin
        e_rdy = 1'b0;
        if (m_t[i] <= total) begin
          int idx;
          idx    = (m_sel[i] + (m_t[i] - 1) / h) % 32;
          e_sel  = 5'(idx);
          e_busy = 1'b1;
          if (m_dir[i]) e_in = 32'd1 << idx;
          else          e_out = 32'd1 << idx;
        end else begin
          e_sel  = 5'((m_sel[i] + m_cnt[i]) % 32);
          e_done = 1'b1;
        end
      end
      chk($sformatf("en_out[h%0d]", h),    64'(eo_s[i]),  64'(e_out));
      chk($sformatf("en_in[h%0d]", h),     64'(ei_s[i]),  64'(e_in));
      chk($sformatf("cur_sel[h%0d]", h),   64'(cs_s[i]),  64'(e_sel));
      chk($sformatf("busy[h%0d]", h),      64'(bsy_s[i]), 64'(e_busy));
      chk($sformatf("done[h%0d]", h),      64'(dn_s[i]),  64'(e_done));
      chk($sformatf("req_ready[h%0d]", h), 64'(rdy_s[i]), 64'(e_rdy));
      chk($sformatf("onehot[h%0d]", h), 64'($countones(eo_s[i] | ei_s[i])), e_busy ? 64'd1 : 64'd0);
      acc_out[i] = acc_out[i] | eo_s[i];
      acc_in[i]  = acc_in[i] | ei_s[i];
      if (dn_s[i])  done_cnt[i]++;
      if (bsy_s[i]) drive_cyc[i]++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    @(negedge clk);
    check_cycle();
  endtask

  // Present one request for a single edge, then run until both instances are idle again.
  task automatic run_req(input logic [4:0] sel, input logic [4:0] cnt, input logic dir);
    int n;
    req_valid = 1'b1;
    req_sel   = sel;
    req_cnt   = cnt;
    req_dir   = dir;
    cycle();
    req_valid = 1'b0;
    n = 0;
    while ((active[0] || active[1]) && n < 200) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 64'(active[0] | active[1]), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_sel   = 5'd7;
    req_cnt   = 5'd2;
    req_dir   = 1'b0;
    abort     = 1'b0;
    model_reset();
    clear_acc();

    // Reset held with a pending request: nothing may start.
    repeat (3) cycle();
    reset_n   = 1'b1;
    req_valid = 1'b0;
    cycle();

    // Single register, Rout.
    clear_acc();
    run_req(5'd5, 5'd0, 1'b0);
    chk("single_acc_out", 64'(acc_out[0]), 64'h20);
    chk("single_acc_in",  64'(acc_in[0]),  64'h0);
    chk("single_done",    64'(done_cnt[0]), 64'd1);
    cycle();

    // Wrapping Rin walk of four registers.
    clear_acc();
    run_req(5'd30, 5'd3, 1'b1);
    chk("wrap_acc_in_h2",  64'(acc_in[1]),    64'hC000_0003);
    chk("wrap_acc_out_h2", 64'(acc_out[1]),   64'h0);
    chk("wrap_cycles_h2",  64'(drive_cyc[1]), 64'd8);
    chk("wrap_cycles_h1",  64'(drive_cyc[0]), 64'd4);
    chk("wrap_done_h2",    64'(done_cnt[1]),  64'd1);

    // All 32 registers.
    clear_acc();
    run_req(5'd0, 5'd31, 1'b0);
    chk("all_acc_h1",    64'(acc_out[0]),   64'hFFFF_FFFF);
    chk("all_cycles_h1", 64'(drive_cyc[0]), 64'd32);
    chk("all_cycles_h2", 64'(drive_cyc[1]), 64'd64);
    chk("all_done_h1",   64'(done_cnt[0]),  64'd1);

    // Abort while the HOLD=1 instance drives register 10.
    clear_acc();
    req_valid = 1'b1;
    req_sel   = 5'd8;
    req_cnt   = 5'd4;
    req_dir   = 1'b0;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("abort_at_sel", 64'(cs_s[0]), 64'd10);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_en_out", 64'(eo_s[0]), 64'h0);
    chk("abort_ready",  64'(rdy_s[0]), 64'd1);
    repeat (4) cycle();
    chk("abort_no_done_h1", 64'(done_cnt[0]), 64'd0);
    chk("abort_no_done_h2", 64'(done_cnt[1]), 64'd0);

    // Asynchronous reset while the HOLD=1 instance drives register 3.
    req_valid = 1'b1;
    req_sel   = 5'd1;
    req_cnt   = 5'd5;
    req_dir   = 1'b0;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("arst_pre_en", 64'(eo_s[0]), 64'h8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_en_out_h1", 64'(eo_s[0]), 64'h0);
    chk("arst_en_out_h2", 64'(eo_s[1]), 64'h0);
    chk("arst_en_in_h1",  64'(ei_s[0]), 64'h0);
    chk("arst_busy_h2",   64'(bsy_s[1]), 64'd0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    cycle();
    clear_acc();
    run_req(5'd20, 5'd1, 1'b1);
    chk("post_arst_acc_in", 64'(acc_in[0]), 64'h0030_0000);

    // Randomized traffic with back-to-back requests and occasional aborts.
    for (int k = 0; k < 3000; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = 5'($urandom_range(0, 31));
      req_cnt   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      req_dir   = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    repeat (80) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_enable_sequencer.md
Name: reg_enable_sequencer

Overview:
- Decoder-side counterpart of the register-select priority encoder.
- Takes a 5-bit register index, a count and a direction. Drives one-hot Rin or Rout enables for the register file, one register at a time, for a programmable hold time per register.
- Used by the control unit for single-register bus transfers and multi-register (block load/store, context save) sequences.
- Sits between the control FSM and the 32-entry register file enable lines.

Parameters:
- N_REGS, 32, number of registers; one-hot enable width.
- SEL_W, 5, index width; log2(N_REGS).
- HOLD, 1, cycles each enable stays asserted; legal range 1..16. Out of range is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_sel  input  SEL_W  first register index.
- req_cnt  input  SEL_W  number of registers minus 1 (0 = single register, 31 = all 32).
- req_dir  input  1  0 = Rout (register drives bus), 1 = Rin (register loads from bus).
- abort  input  1  synchronous cancel of the active sequence.
- en_out  output  N_REGS  one-hot Rout enables.
- en_in  output  N_REGS  one-hot Rin enables.
- cur_sel  output  SEL_W  index currently driven.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE.
  - en_out=0, en_in=0, cur_sel=0, busy=0, done=0, req_ready=1 (after release).
  - All internal counters = 0.
  - Reset mid-sequence drops all enables immediately, without waiting for a clock edge.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - req_ready=1, busy=0, all enables 0.
  - On an edge where req_valid=1: latch req_sel into cur_sel, req_cnt into remaining and req_dir into dir. Clear hold counter. Go to DRIVE.
  - Inputs are ignored when req_valid=0.
- DRIVE:
  - busy=1, req_ready=0.
  - dir=0: en_out = one-hot(cur_sel), en_in=0. dir=1: en_in = one-hot(cur_sel), en_out=0.
  - Exactly one enable bit is high; en_out and en_in are never both nonzero.
  - Hold counter increments each cycle. When hold counter reaches HOLD-1:
    - remaining=0: go to DONE.
    - otherwise: cur_sel = cur_sel+1 modulo N_REGS (index 31 wraps to 0), remaining decrements, hold counter clears, stay in DRIVE.
  - Consecutive registers are driven back-to-back with no idle gap between them.
- DONE:
  - All enables 0, done=1 for exactly one cycle, busy=0, req_ready=0.
  - cur_sel holds the last driven index.
  - Next state is IDLE.
- Outputs are registered. Enables appear the cycle after acceptance.
- Latency: accept edge at cycle T → enables high during cycles T+1 .. T+HOLD*(req_cnt+1) → done high in the following cycle → req_ready high the cycle after that.
- abort:
  - Sampled only in DRIVE. Forces the next state to IDLE with enables 0 and no done pulse.
  - Ignored in IDLE and DONE.
  - abort has priority over hold expiry and over advancing to the next register.
- Back-to-back requests: a request held valid during DONE is accepted on the first IDLE edge.
- req_cnt=31: all 32 registers are visited once, starting at req_sel and wrapping.

Test Plan:
- Reset with req_valid=1 and reset_n held 0 → all enables 0, done=0, busy=0; req_ready=1 after release.
- HOLD=1; req_sel=5, req_cnt=0, req_dir=0 → en_out=0x00000020 for one cycle, en_in=0, then done pulse, then req_ready=1.
- HOLD=2; req_sel=30, req_cnt=3, req_dir=1 → en_in takes bits 30, 31, 0, 1, each for 2 cycles (8 cycles total), cur_sel shows 30→31→0→1, done once, en_out stays 0 throughout.
- req_cnt=31, req_sel=0, HOLD=1 → 32 consecutive single-bit en_out values 0x1 through 0x80000000, then done; exactly one bit set every DRIVE cycle.
- Start req_sel=8, req_cnt=4; assert abort while driving register 10 → enables 0 the next cycle, state IDLE, no done pulse, req_ready=1.
- Drop reset_n while register 3 is driving → en_out/en_in go to 0 without a clock edge; after release the block is in IDLE and accepts a new request normally.
